toggle_pattern_checker: RTL

TOGGLE_PATTERN_CHECKER -- requirements
Module: toggle_pattern_checker

---
 rtl/toggle_chk_pkg.sv | 17 +
 rtl/toggle_ref_gen.sv | 26 ++
 rtl/toggle_pattern_checker.sv | 118 +++++++++++
 3 files changed

// File: rtl/toggle_chk_pkg.sv
// Shared state encoding, pattern constants and default widths for the toggle pattern checker.
package toggle_chk_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 10;
    localparam int ERR_W_DEF  = 16;

    localparam logic PAT_ONES  = 1'b1;
    localparam logic PAT_ZEROS = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/toggle_ref_gen.sv
// Expected-pattern generator: loads all-ones, flips between all-ones and all-zeros on each advance.
module toggle_ref_gen
    import toggle_chk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] expected
);

    logic phase_p0;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            phase_p0 <= PAT_ONES;
        end else if (advance) begin
            phase_p0 <= ~phase_p0;
        end
    end

    assign expected = phase_p0 ? {DATA_W{PAT_ONES}} : {DATA_W{PAT_ZEROS}};

endmodule

// File: rtl/toggle_pattern_checker.sv
// Checks read-back bursts against an alternating FF/00 pattern, counting and capturing mismatches.
// Optional per-bit compare mask enabled by defining TOGGLE_CHK_MASK_EN.
module toggle_pattern_checker
    import toggle_chk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int ERR_W  = ERR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_addr,
`ifdef TOGGLE_CHK_MASK_EN
    input  logic [DATA_W-1:0] chk_mask,
`endif
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [LEN_W-1:0]  fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_cnt;
    logic [DATA_W-1:0]  expected;
    logic [DATA_W-1:0]  mask;
    logic               vld_p0;
    logic               mismatch_p0;
    logic               last_beat;

`ifdef TOGGLE_CHK_MASK_EN
    logic [DATA_W-1:0]  mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
        end else if (start) begin
            mask_q <= chk_mask;
        end
    end

    assign mask = mask_q;
`else
    assign mask = '1;
`endif

    // A beat is consumed only in CHECK; a coincident start wins and drops it.
    assign vld_p0      = (state == CHECK) && in_valid && !start;
    assign mismatch_p0 = vld_p0 && (((in_data ^ expected) & mask) != '0);
    assign last_beat   = (beat_cnt == len_q - LEN_W'(1));

    toggle_ref_gen #(
        .DATA_W (DATA_W)
    ) u_ref_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .advance  (vld_p0),
        .expected (expected)
    );

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = (len == '0) ? DONE : CHECK;
        end else if (vld_p0 && last_beat) begin
            state_nxt = DONE;
        end
    end

    // Register stage: state, flags and counters reflect the beat presented last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            beat_cnt  <= '0;
            len_q     <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == CHECK);
            done  <= (state_nxt == DONE);
            if (start) begin
                fail      <= 1'b0;
                err_cnt   <= '0;
                fail_addr <= '0;
                fail_data <= '0;
                beat_cnt  <= '0;
                len_q     <= len;
            end else if (vld_p0) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
                if (mismatch_p0) begin
                    err_cnt <= sat_inc(err_cnt);
                    if (!fail) begin
                        fail      <= 1'b1;
                        fail_addr <= in_addr;
                        fail_data <= in_data;
                    end
                end
            end
        end
    end

endmodule
